uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the transmitter (legal range 2..8).
REQ-002 Parameter DATA_W, default 8, frame data bits.
REQ-003 Parameter OVERSAMPLE, default 16, baud_clk rising edges per bit.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 baud_clk  input  1  free-running toggling oversample clock from the baud generator; sampled as data in the clk domain.
REQ-007 req  input  N_REQ  per-requester transmit request; held high until granted.
REQ-008 data_in  input  N_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 gnt  output  N_REQ  one-hot, single-cycle accept pulse.
REQ-010 gnt_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-011 busy  output  1  high while a frame is in flight.
REQ-012 tx  output  1  serial line; idle high.

Function
REQ-013 Tick SHALL be a one-clk pulse on each baud_clk 0->1 transition, detected against a registered copy of baud_clk.
REQ-014 FSM SHALL have the states IDLE, START, DATA, STOP, plus PARITY when the parity macro is defined.
REQ-015 In IDLE, with any req bit high at a clk edge, the next cycle SHALL assert gnt[w] for exactly one cycle, set gnt_id=w, latch data_in slice w, set busy=1, tx=0, state=START, and clear the tick counter.
REQ-016 Winner w SHALL be the first requester with req high, searching round-robin from (last gnt_id+1) mod N_REQ.
REQ-017 Each bit state SHALL last exactly OVERSAMPLE ticks; ticks received in IDLE are ignored.
REQ-018 DATA SHALL shift out DATA_W bits, LSB first, then go to PARITY or STOP.
REQ-019 STOP SHALL drive tx=1 for OVERSAMPLE ticks; on its last tick, state=IDLE and busy=0 in the same cycle.
REQ-020 A grant SHALL be issued only from IDLE, so a minimum of one clk separates back-to-back frames; no grant is issued while busy=1.
REQ-021 A req dropped before its grant SHALL receive no grant; changes to req or data_in after the grant SHALL not affect the frame in flight.
REQ-022 Frame length: (DATA_W+2)*OVERSAMPLE ticks, or (DATA_W+3)*OVERSAMPLE ticks with parity.

Reset
REQ-023 rst SHALL force tx=1, busy=0, gnt=0, gnt_id=N_REQ-1 (so requester 0 wins first), state=IDLE, counters=0, baud_clk register=0.
REQ-024 rst asserted mid-frame SHALL abort the frame, with tx=1 on the following cycle and no grant or completion indication.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, PARITY SHALL follow DATA and drive the even-parity bit (XOR of the data bits) for OVERSAMPLE ticks.
REQ-026 Without UART_TX_PARITY_EN, no PARITY state or parity logic SHALL exist, and DATA SHALL go directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE default and the idle-line constant.
REQ-028 Sub-module baud_tick_detect (baud_clk register plus rising-edge pulse) SHALL be instantiated once.

Verification
REQ-029 Single request: req=4'b0010, data_in[15:8]=8'hA5 -> gnt=4'b0010 for 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; busy falls after 160 ticks.
REQ-030 Round-robin: req=4'b1111 held, refreshed after each grant -> gnt_id sequence 0,1,2,3,0.
REQ-031 Request during frame: req[3] raised while busy=1 -> no gnt until busy=0; gnt[3] the cycle after IDLE is sampled with req[3]=1.
REQ-032 Reset mid-DATA: assert rst at tick 50 of a frame -> tx=1, busy=0, gnt=0 next cycle; next grant goes to requester 0.
REQ-033 UART_TX_PARITY_EN defined, data 8'h07 -> parity bit 1; frame length 176 ticks.
REQ-034 Tick detect: baud_clk held high for 5 clk cycles -> exactly one tick; no baud_clk toggling while busy -> tx and state frozen.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit state).
package uart_pkg;

   localparam int   OVERSAMPLE_DEFAULT = 16;
   localparam logic TX_IDLE            = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } tx_state_e;

   // Counter width that stays legal for a modulus of 1.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/baud_tick_detect.sv
// Turns the free-running baud_clk, sampled as data, into a one-clk tick
// on every 0->1 transition.
module baud_tick_detect (
   input  logic clk,
   input  logic rst,
   input  logic baud_clk,
   output logic tick
);

   logic baud_q;
   logic baud_d;

   always_comb begin
      baud_d = baud_clk;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_q <= 1'b0;
      end else begin
         baud_q <= baud_d;
      end
   end

   assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter (8N1 style framing).
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data).
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      baud_clk,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data_in,
   output logic [N_REQ-1:0]          gnt,
   output logic [$clog2(N_REQ)-1:0]  gnt_id,
   output logic                      busy,
   output logic                      tx
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int TICK_W = cnt_width(OVERSAMPLE);
   localparam int BIT_W  = cnt_width(DATA_W);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [ID_W-1:0]   ID_RESET  = ID_W'(N_REQ - 1);

   tx_state_e          state_q, state_d;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic               busy_q, busy_d;
   logic               tx_q, tx_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic               tick;
   logic               last_tick;
   logic               found;
   logic [ID_W-1:0]    winner;

   baud_tick_detect u_tick (
      .clk      (clk),
      .rst      (rst),
      .baud_clk (baud_clk),
      .tick     (tick)
   );

   // Search starts just after the last granted requester.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(gnt_id_q) + 1 + i) % N_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latches.
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      gnt_d      = '0;
      gnt_id_d   = gnt_id_q;
      busy_d     = busy_q;
      tx_d       = tx_q;
      shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      last_tick = tick && (tick_cnt_q == TICK_LAST);

      if (tick && (state_q != IDLE)) begin
         tick_cnt_d = last_tick ? '0 : tick_cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d        = START;
               gnt_d[winner]  = 1'b1;
               gnt_id_d       = winner;
               busy_d         = 1'b1;
               tx_d           = 1'b0;
               tick_cnt_d     = '0;
               bit_cnt_d      = '0;
               shift_d        = data_in[int'(winner)*DATA_W +: DATA_W];
`ifdef UART_TX_PARITY_EN
               parity_d       = ^data_in[int'(winner)*DATA_W +: DATA_W];
`endif
            end
         end

         START: begin
            if (last_tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end

         DATA: begin
            if (last_tick) begin
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = parity_q;
`else
                  state_d = STOP;
                  tx_d    = TX_IDLE;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_d[0];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (last_tick) begin
               state_d = STOP;
               tx_d    = TX_IDLE;
            end
         end
`endif

         STOP: begin
            if (last_tick) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         gnt_q      <= '0;
         gnt_id_q   <= ID_RESET;
         busy_q     <= 1'b0;
         tx_q       <= TX_IDLE;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         busy_q     <= busy_d;
         tx_q       <= tx_d;
      end
   end

   // NOTE: payload registers are not reset; they are always loaded at grant before use.
   always_ff @(posedge clk) begin
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;
   assign tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default parameters).
// Expectations follow UART_TX_PARITY_EN when the build defines it.
module tb_uart_tx_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int OS     = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DATA_W + 3;
`else
   localparam int NB = DATA_W + 2;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    baud_clk;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] data_in;
   logic [N_REQ-1:0]        gnt;
   logic [1:0]              gnt_id;
   logic                    busy;
   logic                    tx;

   int checks    = 0;
   int failures  = 0;
   int stray_gnt = 0;

   uart_tx_arbiter #(
      .N_REQ      (N_REQ),
      .DATA_W     (DATA_W),
      .OVERSAMPLE (OS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_clk (baud_clk),
      .req      (req),
      .data_in  (data_in),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .busy     (busy),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One tick = baud_clk high for one clk, low for one clk; returns at a negedge.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (gnt != '0) stray_gnt++;
         baud_clk = 1'b1;
         @(negedge clk);
         if (gnt != '0) stray_gnt++;
         baud_clk = 1'b0;
      end
   endtask

   task automatic wait_gnt(input string tag, input int exp_id);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == '0 && n < 20);
      check({tag, "_seen"}, 32'(gnt != '0), 1);
      check({tag, "_id"},   32'(gnt_id), exp_id);
      check({tag, "_gnt"},  32'(gnt), 32'(1 << exp_id));
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_start"}, 32'(tx), 0);
   endtask

   // Called at the grant negedge; samples each bit mid-way and checks frame end.
   task automatic check_frame(input string tag, input logic [DATA_W-1:0] d);
      logic [NB-1:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < DATA_W; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      bits[DATA_W+1] = ^d;
`endif
      bits[NB-1] = 1'b1;
      for (int k = 0; k < NB; k++) begin
         ticks(8);
         check($sformatf("%s_bit%0d", tag, k), 32'(tx), 32'(bits[k]));
         if (k < NB - 1) begin
            ticks(8);
         end else begin
            ticks(7);
            check({tag, "_busy_end-1"}, 32'(busy), 1);
            ticks(1);
            check({tag, "_busy_end"}, 32'(busy), 0);
            check({tag, "_tx_idle"}, 32'(tx), 1);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      baud_clk = 1'b0;
      req      = '0;
      data_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_tx",   32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt",  32'(gnt), 0);
      check("rst_id",   32'(gnt_id), 3);
      rst = 1'b0;

      // Single request; payload changed after grant must not leak into the frame.
      data_in = {8'h11, 8'h22, 8'hA5, 8'h33};
      req     = 4'b0010;
      wait_gnt("single", 1);
      req           = '0;
      data_in[15:8] = 8'h00;
      stray_gnt     = 0;
      check_frame("single", 8'hA5);
      check("single_gnt_pulse", 32'(stray_gnt), 0);

      // Round robin from reset with all requests held.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_gnt($sformatf("rr%0d", f), f % 4);
         ticks(NB * OS);
      end
      req = '0;

      // Requests raised while busy; req[1] is withdrawn before the frame ends.
      data_in = {8'h00, 8'h22, 8'h44, 8'h5A};
      req     = 4'b0001;
      wait_gnt("rq0", 0);
      req       = '0;
      stray_gnt = 0;
      ticks(20);
      req = 4'b1010;
      ticks(40);
      req = 4'b1000;
      ticks(NB * OS - 60);
      check("busy_no_gnt", 32'(stray_gnt), 0);
      @(negedge clk);
      check("late_gnt", 32'(gnt), 32'(4'b1000));
      check("late_id",  32'(gnt_id), 3);
      req = '0;

      // Reset at tick 50 (inside DATA, payload bits all zero).
      ticks(50);
      check("pre_rst_tx", 32'(tx), 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx",   32'(tx), 1);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_gnt",  32'(gnt), 0);
      check("mid_rst_id",   32'(gnt_id), 3);
      rst           = 1'b0;
      data_in[7:0]  = 8'h3D;
      req           = 4'b1111;
      wait_gnt("post_rst", 0);
      req = '0;

      // baud_clk held high for 5 clks counts once; then freeze with no ticks.
      baud_clk = 1'b1;
      repeat (5) @(negedge clk);
      baud_clk = 1'b0;
      ticks(14);
      check("long_high_start", 32'(tx), 0);
      ticks(1);
      check("long_high_bit0", 32'(tx), 1);
      repeat (40) @(negedge clk);
      check("freeze_tx",   32'(tx), 1);
      check("freeze_busy", 32'(busy), 1);
      ticks(15);
      check("freeze_bit0_held", 32'(tx), 1);
      ticks(1);
      check("freeze_bit1", 32'(tx), 0);
      ticks(NB * OS - 33);
      check("freeze_busy_end-1", 32'(busy), 1);
      ticks(1);
      check("freeze_busy_end", 32'(busy), 0);

      // 8'h07 frame: parity bit 1 and 176-tick length when parity is built in.
      data_in[7:0] = 8'h07;
      req          = 4'b0001;
      wait_gnt("par", 0);
      req = '0;
      check_frame("par", 8'h07);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
